line_buffer_scheduler: RTL and testbench
========================================

# line_buffer_scheduler

Sequencing controller for the 12-row line-buffer stack that feeds the 13x13 filter window. It admits one frame of raster pixels, drives the stack's shift enable, and injects zero padding rows at end of frame so every image pixel gets a window centred on it. It also reports the window centre position and row-validity mask, and flags completion. It sits between the pixel source and the line-buffer stack/window datapath.

## Interface
- WIDTH, 17, pixels per line; must equal the line-buffer DEPTH
- HEIGHT, 17, lines per frame
- ROWS, 12, number of line buffers; window height ROWS+1; must be even
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- start_i  input  1  frame start request, sampled in IDLE
- valid_i  input  1  source pixel valid
- ready_o  output  1  controller accepts a pixel this cycle
- shift_en_o  output  1  advance line-buffer stack this cycle
- pad_sel_o  output  1  stack input selects 8'd0 instead of source pixel
- win_valid_o  output  1  window at stack outputs is valid this cycle
- row_o  output  $clog2(HEIGHT)  window centre row
- col_o  output  $clog2(WIDTH)  window centre column
- row_mask_o  output  ROWS+1  bit k=1: tap k (k lines delayed) lies inside the image
- busy_o  output  1  not IDLE
- done_o  output  1  one-cycle pulse, frame finished

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE: start_i=1 -> STREAM, counters cleared. valid_i ignored; start_i during any other state ignored.
- Counters: col c in 0..WIDTH-1; line r in 0..HEIGHT+ROWS/2-1. Both advance only on shift_en_o. c wraps to 0 and r increments at c=WIDTH-1.
- STREAM: ready_o=1, shift_en_o=valid_i, pad_sel_o=0. On the shift with r=HEIGHT-1, c=WIDTH-1 -> FLUSH.
- FLUSH: ready_o=0, shift_en_o=1 every cycle, pad_sel_o=1. On the shift with r=HEIGHT+ROWS/2-1, c=WIDTH-1 -> DONE.
- DONE: done_o=1 for one cycle -> IDLE.
- win_valid_o = shift_en_o & (r >= ROWS/2). row_o = r-ROWS/2. col_o = c. Both are meaningful only while win_valid_o=1.
- row_mask_o bit k = (r-k >= 0) & (r-k < HEIGHT), evaluated in signed arithmetic one bit wider than r.
- Total shifts per frame = WIDTH*(HEIGHT+ROWS/2). Windows per frame = WIDTH*HEIGHT.
- Stale data from the previous frame is never cleared in the stack. The downstream datapath must use row_mask_o to zero those taps.

## Timing
- shift_en_o, ready_o, pad_sel_o, win_valid_o, row_o, col_o, row_mask_o are combinational from state, counters and valid_i. They describe the shift in the same cycle, with zero latency.
- done_o is registered and asserts the cycle after the final flush shift.
- Reset values: state IDLE, counters 0. Outputs: ready_o=0, shift_en_o=0, pad_sel_o=0, win_valid_o=0, busy_o=0, done_o=0, row_o=0, col_o=0, row_mask_o=0.
- Source gaps: valid_i low in STREAM holds counters and emits nothing. Gaps are unlimited.
- Reset assertion mid-frame returns to IDLE at once, without a done_o pulse.
- A frame start is accepted one cycle after done_o at the earliest.

## Configuration
- LB_SCHED_ROW_MASK_EN defined: row_mask_o is computed as above.
- LB_SCHED_ROW_MASK_EN undefined: row_mask_o is tied to all ones and the mask logic is not built. The downstream datapath then sees stale and pad rows unmasked. This is acceptable only where border pixels are discarded.

## Structure
- Package lb_sched_pkg holds the state enum (IDLE, STREAM, FLUSH, DONE) and the default WIDTH/HEIGHT/ROWS constants.
- One sub-module, frame_pos_counter: column/line counters with an enable, wrap and last-position flags.

## Test plan
- Reset, then an 8-bit ramp frame with valid_i always high, defaults -> 391 shift_en_o pulses and 289 win_valid_o pulses. First window at shift index 102 with row_o=0, col_o=0. done_o asserts once, one cycle after the 391st shift.
- Random valid_i gaps (50%) -> same 289 windows in the same row/col order. No shift occurs while valid_i=0. ready_o stays low throughout FLUSH.
- row_mask_o checks: at row_o=0 it equals 13'b0000001111111; at row_o=8 it equals 13'b1111111111111; at row_o=16 it equals 13'b1111111000000.
- start_i held high during STREAM and FLUSH -> no restart. A second frame started right after done_o -> identical window count.
- rst pulled low at shift 200 -> all outputs reach reset values immediately. A new frame then runs normally.
- Build without LB_SCHED_ROW_MASK_EN -> row_mask_o=13'h1FFF on every window. Counts are unchanged.

Source files
------------

// File: rtl/line_buffer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lb_sched_pkg
// Purpose  : Shared types and default geometry for the line-buffer scheduler.
//            Holds the controller state encoding and the default
//            WIDTH/HEIGHT/ROWS values used by the top level.
// Revision : 1.0 - initial release
// ============================================================================
package lb_sched_pkg;

    localparam int DEF_WIDTH  = 17;
    localparam int DEF_HEIGHT = 17;
    localparam int DEF_ROWS   = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } lb_state_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer_scheduler_frame_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_pos_counter
// Purpose  : Column/line position counters for the scheduler. The column
//            counts 0..WIDTH-1 and the line counts 0..LINES-1; both advance
//            only when en is high. Reaching the end of the last line wraps
//            both back to zero.
// Ports    : clk, rst (async, active-low), clear (sync zero), en (advance),
//            col/line (current position), col_last/line_last (at last value)
// Revision : 1.0 - initial release
// ============================================================================
module frame_pos_counter #(
    parameter int WIDTH = 17,
    parameter int LINES = 23,
    parameter int CW    = $clog2(WIDTH),
    parameter int LW    = $clog2(LINES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [LW-1:0] line,
    output logic          col_last,
    output logic          line_last
);

    assign col_last  = (col == CW'(WIDTH - 1));
    assign line_last = (line == LW'(LINES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col  <= '0;
            line <= '0;
        end else if (clear) begin
            col  <= '0;
            line <= '0;
        end else if (en) begin
            if (col_last) begin
                col  <= '0;
                line <= line_last ? '0 : line + LW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_scheduler
// Purpose  : Sequencing controller for the ROWS-deep line-buffer stack that
//            feeds the (ROWS+1)x(ROWS+1) filter window. Streams one frame of
//            raster pixels, then injects ROWS/2 zero-pad lines so every image
//            pixel gets a centred window. Reports window centre, row-validity
//            mask and a one-cycle done pulse.
// Ports    : clk, rst (async, active-low), start_i, valid_i -> ready_o,
//            shift_en_o, pad_sel_o, win_valid_o, row_o, col_o, row_mask_o,
//            busy_o, done_o
// Config   : LB_SCHED_ROW_MASK_EN - build the row-validity mask; when
//            undefined row_mask_o is tied to all ones.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_scheduler
    import lb_sched_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ROWS   = DEF_ROWS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic                      shift_en_o,
    output logic                      pad_sel_o,
    output logic                      win_valid_o,
    output logic [$clog2(HEIGHT)-1:0] row_o,
    output logic [$clog2(WIDTH)-1:0]  col_o,
    output logic [ROWS:0]             row_mask_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int HALF  = ROWS / 2;
    localparam int LINES = HEIGHT + HALF;
    localparam int CW    = $clog2(WIDTH);
    localparam int LW    = $clog2(LINES);
    localparam int RW    = $clog2(HEIGHT);

    lb_state_t     state;
    lb_state_t     state_next;
    logic          clear;
    logic          frame_end;
    logic [CW-1:0] col;
    logic [LW-1:0] line;
    logic          col_last;
    logic          line_last;

    frame_pos_counter #(
        .WIDTH (WIDTH),
        .LINES (LINES),
        .CW    (CW),
        .LW    (LW)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .en        (shift_en_o),
        .col       (col),
        .line      (line),
        .col_last  (col_last),
        .line_last (line_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            state  <= state_next;
            done_o <= frame_end;
        end
    end

    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        shift_en_o = 1'b0;
        pad_sel_o  = 1'b0;
        clear      = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    clear      = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                ready_o    = 1'b1;
                shift_en_o = valid_i;
                if (valid_i && col_last && (line == LW'(HEIGHT - 1))) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                shift_en_o = 1'b1;
                pad_sel_o  = 1'b1;
                if (col_last && line_last) begin
                    frame_end  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_o      = (state != IDLE);
    assign win_valid_o = shift_en_o && (line >= LW'(HALF));
    assign col_o       = col;
    // Gated so the centre row reads zero outside a window instead of a
    // wrapped negative offset.
    assign row_o       = win_valid_o ? RW'(line - LW'(HALF)) : '0;

`ifdef LB_SCHED_ROW_MASK_EN
    logic [ROWS:0] mask_raw;

    // Tap k holds the line written k shifts-of-a-line ago; it is real image
    // data only when that line index falls inside 0..HEIGHT-1.
    for (genvar k = 0; k <= ROWS; k++) begin : g_mask_bit
        localparam logic signed [LW:0] TAP = (LW + 1)'(k);
        localparam logic signed [LW:0] LIM = (LW + 1)'(HEIGHT);
        logic signed [LW:0] diff;
        assign diff        = $signed({1'b0, line}) - TAP;
        assign mask_raw[k] = !diff[LW] && (diff < LIM);
    end

    assign row_mask_o = win_valid_o ? mask_raw : '0;
`else
    assign row_mask_o = '1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buffer_scheduler
// Purpose  : Self-checking bench for line_buffer_scheduler. A shift-index
//            reference model derives every expected output from the frame
//            geometry; a small table checks the row mask at chosen rows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_buffer_scheduler;

    localparam int W     = 17;
    localparam int H     = 17;
    localparam int ROWS  = 12;
    localparam int HALF  = ROWS / 2;
    localparam int NPIX  = W * H;
    localparam int TOTAL = W * (H + HALF);
`ifdef LB_SCHED_ROW_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        valid_i;
    logic        ready_o;
    logic        shift_en_o;
    logic        pad_sel_o;
    logic        win_valid_o;
    logic [4:0]  row_o;
    logic [4:0]  col_o;
    logic [12:0] row_mask_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          row;
        logic [12:0] mask;
    } mask_vec_t;

    mask_vec_t   tbl[5];
    logic [12:0] mask_seen[H];

    line_buffer_scheduler #(.WIDTH(W), .HEIGHT(H), .ROWS(ROWS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .shift_en_o  (shift_en_o),
        .pad_sel_o   (pad_sel_o),
        .win_valid_o (win_valid_o),
        .row_o       (row_o),
        .col_o       (col_o),
        .row_mask_o  (row_mask_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Tap k sees image line (r-k); it is valid when that line exists.
    function automatic logic [12:0] model_mask(input int r);
        logic [12:0] m;
        m = '0;
        if (!MASK_EN) return 13'h1FFF;
        for (int k = 0; k <= ROWS; k++) begin
            if ((r - k) >= 0 && (r - k) < H) m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready_o, 0);
        chk({tag, "_shift"}, shift_en_o, 0);
        chk({tag, "_pad"}, pad_sel_o, 0);
        chk({tag, "_win"}, win_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_row"}, row_o, 0);
        chk({tag, "_col"}, col_o, 0);
        chk({tag, "_mask"}, row_mask_o, MASK_EN ? 13'h0 : 13'h1FFF);
    endtask

    // One frame: IDLE start cycle, then shifts tracked by shift index n,
    // then the done cycle. abort_at >= 0 pulls reset after that many shifts.
    task automatic run_frame(input int gap_pct, input bit hold_start,
                             input int abort_at, input bit record);
        int n, cyc, dut_shifts, dut_wins, first_n, r, c;
        bit exp_ready, exp_shift, exp_pad, exp_win;
        n = 0; cyc = 0; dut_shifts = 0; dut_wins = 0; first_n = -1;

        @(posedge clk); #1;
        start_i = 1'b1;
        valid_i = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("idle_shift", shift_en_o, 0);
        chk("idle_ready", ready_o, 0);

        while (n < TOTAL && cyc < 5000) begin
            @(posedge clk); #1;
            start_i = hold_start;
            valid_i = (int'($urandom_range(99)) >= gap_pct);
            if (n == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("midrst");
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
            exp_ready = (n < NPIX);
            exp_shift = (n < NPIX) ? valid_i : 1'b1;
            exp_pad   = (n >= NPIX);
            r = n / W;
            c = n % W;
            exp_win = exp_shift && (r >= HALF);
            chk("ready", ready_o, exp_ready);
            chk("shift_en", shift_en_o, exp_shift);
            chk("pad_sel", pad_sel_o, exp_pad);
            chk("win_valid", win_valid_o, exp_win);
            chk("busy", busy_o, 1);
            chk("done_early", done_o, 0);
            if (exp_win) begin
                chk("row", row_o, r - HALF);
                chk("col", col_o, c);
                chk("mask", row_mask_o, model_mask(r));
                if (record && c == 0) mask_seen[r - HALF] = row_mask_o;
            end
            if (shift_en_o === 1'b1) dut_shifts++;
            if (win_valid_o === 1'b1) begin
                if (first_n < 0) first_n = n;
                dut_wins++;
            end
            if (exp_shift) n++;
            cyc++;
        end
        if (n < TOTAL) chk("frame_timeout", n, TOTAL);

        @(posedge clk); #1;
        start_i = hold_start;
        valid_i = 1'b1;
        @(negedge clk);
        chk("done_pulse", done_o, 1);
        chk("done_busy", busy_o, 1);
        chk("done_shift", shift_en_o, 0);
        chk("done_ready", ready_o, 0);
        chk("shift_count", dut_shifts, TOTAL);
        chk("win_count", dut_wins, NPIX);
        chk("first_win_idx", first_n, HALF * W);
    endtask

    initial begin
        tbl[0] = '{row: 0,  mask: MASK_EN ? 13'b0000001111111 : 13'h1FFF};
        tbl[1] = '{row: 3,  mask: MASK_EN ? 13'b0001111111111 : 13'h1FFF};
        tbl[2] = '{row: 8,  mask: MASK_EN ? 13'b1111111111111 : 13'h1FFF};
        tbl[3] = '{row: 13, mask: MASK_EN ? 13'b1111111111000 : 13'h1FFF};
        tbl[4] = '{row: 16, mask: MASK_EN ? 13'b1111111000000 : 13'h1FFF};
        for (int i = 0; i < H; i++) mask_seen[i] = 'x;

        rst     = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // valid_i alone must not start anything
        @(posedge clk); #1;
        valid_i = 1'b1;
        @(negedge clk);
        chk("idle_valid_shift", shift_en_o, 0);
        chk("idle_valid_busy", busy_o, 0);

        run_frame(0, 1'b0, -1, 1'b0);     // ramp frame, no gaps
        run_frame(50, 1'b0, -1, 1'b1);    // back-to-back start, random gaps

        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mask_tbl_row%0d", tbl[i].row), mask_seen[tbl[i].row], tbl[i].mask);
        end

        run_frame(30, 1'b1, -1, 1'b0);    // start_i held through the frame
        run_frame(0, 1'b0, 200, 1'b0);    // reset after 200 shifts
        run_frame(20, 1'b0, -1, 1'b0);    // recovery frame

        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("final_busy", busy_o, 0);
        chk("final_done", done_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
